control_seq: RTL and testbench



---
 rtl/control_seq_if.sv | 24 ++
 rtl/control_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_control_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_seq_if.sv
// Instruction channel between the issue side and the control sequencer:
// opcode/func handshake plus the ALU compare and memory-complete strobes.
interface control_seq_if #(
    parameter int OP_W   = 3,
    parameter int FUNC_W = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   Opcode;
    logic [FUNC_W-1:0] Func;
    logic              alu_eq;
    logic              alu_lt;
    logic              mem_ack;

    modport master (
        output instr_valid, Opcode, Func, alu_eq, alu_lt, mem_ack,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, Opcode, Func, alu_eq, alu_lt, mem_ack,
        output instr_ready
    );
endinterface

// File: rtl/control_seq.sv
// Control sequencer: decodes one instruction per accepted handshake into
// registered one-cycle control pulses, with memory wait/timeout and halt.
module control_seq #(
    parameter int OP_W        = 3,
    parameter int FUNC_W      = 3,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               start,
    control_seq_if.slave       bus,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               SetSrcReg,
    output logic               SetDesReg,
    output logic               branch,
    output logic               branchEq,
    output logic               branchLT,
    output logic               done,
    output logic               illegal,
    output logic               mem_err,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_WAIT, S_HALT} state_t;

    state_t               r_state, w_state;
    logic [ALUOP_W-1:0]   r_aluop, w_aluop;
    logic                 r_regwrite, w_regwrite;
    logic                 r_memread, w_memread;
    logic                 r_memwrite, w_memwrite;
    logic                 r_setsrc, w_setsrc;
    logic                 r_setdes, w_setdes;
    logic                 r_branch, w_branch;
    logic                 r_beq, w_beq;
    logic                 r_blt, w_blt;
    logic                 r_done, w_done;
    logic                 r_illegal, w_illegal;
    logic                 r_mem_err, w_mem_err;
    logic                 r_ready, w_ready;
    logic                 r_eq_flag, w_eq_flag;
    logic                 r_lt_flag, w_lt_flag;
    logic [WAIT_W-1:0]    r_wait, w_wait;
    logic [CNT_W-1:0]     r_count, w_count;
    logic                 w_accept;

    assign w_accept = bus.instr_valid && r_ready;

    always_comb begin
        w_state    = r_state;
        w_aluop    = '0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_setsrc   = 1'b0;
        w_setdes   = 1'b0;
        w_branch   = 1'b0;
        w_beq      = 1'b0;
        w_blt      = 1'b0;
        w_illegal  = 1'b0;
        w_done     = r_done;
        w_mem_err  = r_mem_err;
        w_eq_flag  = r_eq_flag;
        w_lt_flag  = r_lt_flag;
        w_wait     = '0;
        w_count    = r_count;

        case (r_state)
            S_IDLE: begin
                if (start) w_state = S_RUN;
            end

            S_RUN: begin
                if (w_accept) begin
                    if (r_count != '1) w_count = r_count + CNT_W'(1);
                    case (bus.Opcode)
                        OP_W'(0): begin
                            case (bus.Func)
                                FUNC_W'(1), FUNC_W'(2), FUNC_W'(3),
                                FUNC_W'(4), FUNC_W'(5): begin
                                    w_regwrite = 1'b1;
                                    w_aluop    = ALUOP_W'(bus.Func);
                                end
                                FUNC_W'(6): begin
                                    w_aluop   = ALUOP_W'(bus.Func);
                                    w_eq_flag = bus.alu_eq;
                                end
                                FUNC_W'(7): begin
                                    w_aluop   = ALUOP_W'(bus.Func);
                                    w_lt_flag = bus.alu_lt;
                                end
                                default: w_illegal = 1'b1;
                            endcase
                        end
                        OP_W'(1): begin
                            case (bus.Func)
                                FUNC_W'(0): w_setdes   = 1'b1;
                                FUNC_W'(1): w_setsrc   = 1'b1;
                                FUNC_W'(2): w_regwrite = 1'b1;
                                FUNC_W'(3): begin
                                    w_memread = 1'b1;
                                    w_state   = S_MEM_WAIT;
                                end
                                FUNC_W'(4): begin
                                    w_memwrite = 1'b1;
                                    w_state    = S_MEM_WAIT;
                                end
                                FUNC_W'(5): begin
                                    w_done  = 1'b1;
                                    w_state = S_HALT;
                                end
                                default: w_illegal = 1'b1;
                            endcase
                        end
                        OP_W'(2): begin
                            // Flags were committed at the previous acceptance edge,
                            // so a compare immediately followed by a branch sees it.
                            case (bus.Func)
                                FUNC_W'(0): w_branch = 1'b1;
                                FUNC_W'(1): begin
                                    w_beq    = 1'b1;
                                    w_branch = r_eq_flag;
                                end
                                FUNC_W'(2): begin
                                    w_blt    = 1'b1;
                                    w_branch = r_lt_flag;
                                end
                                default: w_illegal = 1'b1;
                            endcase
                        end
                        default: w_illegal = 1'b1;
                    endcase
                end
            end

            S_MEM_WAIT: begin
                // An ack arriving in the last allowed cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    w_regwrite = r_memread;
                    w_state    = S_RUN;
                end else if (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    w_mem_err = 1'b1;
                    w_done    = 1'b1;
                    w_state   = S_HALT;
                end else begin
                    w_memread  = r_memread;
                    w_memwrite = r_memwrite;
                    w_wait     = r_wait + WAIT_W'(1);
                end
            end

            S_HALT: begin
                if (start) begin
                    w_state   = S_RUN;
                    w_done    = 1'b0;
                    w_mem_err = 1'b0;
                    w_eq_flag = 1'b0;
                    w_lt_flag = 1'b0;
                end
            end

            default: w_state = S_IDLE;
        endcase

        w_ready = (w_state == S_RUN);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_aluop    <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_setsrc   <= 1'b0;
            r_setdes   <= 1'b0;
            r_branch   <= 1'b0;
            r_beq      <= 1'b0;
            r_blt      <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_mem_err  <= 1'b0;
            r_ready    <= 1'b0;
            r_eq_flag  <= 1'b0;
            r_lt_flag  <= 1'b0;
            r_wait     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state;
            r_aluop    <= w_aluop;
            r_regwrite <= w_regwrite;
            r_memread  <= w_memread;
            r_memwrite <= w_memwrite;
            r_setsrc   <= w_setsrc;
            r_setdes   <= w_setdes;
            r_branch   <= w_branch;
            r_beq      <= w_beq;
            r_blt      <= w_blt;
            r_done     <= w_done;
            r_illegal  <= w_illegal;
            r_mem_err  <= w_mem_err;
            r_ready    <= w_ready;
            r_eq_flag  <= w_eq_flag;
            r_lt_flag  <= w_lt_flag;
            r_wait     <= w_wait;
            r_count    <= w_count;
        end
    end

    assign bus.instr_ready = r_ready;
    assign ALUOp           = r_aluop;
    assign RegWrite        = r_regwrite;
    assign MemRead         = r_memread;
    assign MemWrite        = r_memwrite;
    assign SetSrcReg       = r_setsrc;
    assign SetDesReg       = r_setdes;
    assign branch          = r_branch;
    assign branchEq        = r_beq;
    assign branchLT        = r_blt;
    assign done            = r_done;
    assign illegal         = r_illegal;
    assign mem_err         = r_mem_err;
    assign instr_count     = r_count;

endmodule

// File: tb/tb_control_seq.sv
// Randomized bench for control_seq against a transaction-level decode model;
// a small counter width makes saturation reachable quickly.
module tb_control_seq;
    localparam int OP_W = 3, FUNC_W = 3, ALUOP_W = 3, MEM_TIMEOUT = 8, CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0] aluop;
        logic rw, mr, mw, ssrc, sdes, br, beq, blt, dn, ill, merr, rdy;
    } ov_t;

    logic CLK = 1'b0, Reset_n = 1'b1, start = 1'b0;
    logic [ALUOP_W-1:0] ALUOp;
    logic RegWrite, MemRead, MemWrite, SetSrcReg, SetDesReg;
    logic branch, branchEq, branchLT, done, illegal, mem_err;
    logic [CNT_W-1:0] instr_count;

    control_seq_if #(.OP_W(OP_W), .FUNC_W(FUNC_W)) bus();

    control_seq #(.OP_W(OP_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W),
                  .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .start(start), .bus(bus),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .SetSrcReg(SetSrcReg), .SetDesReg(SetDesReg), .branch(branch),
        .branchEq(branchEq), .branchLT(branchLT), .done(done), .illegal(illegal),
        .mem_err(mem_err), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;
    bit m_eq, m_lt;
    int m_cnt;

    function automatic ov_t obs();
        obs = {ALUOp, RegWrite, MemRead, MemWrite, SetSrcReg, SetDesReg,
               branch, branchEq, branchLT, done, illegal, mem_err, bus.instr_ready};
    endfunction

    function automatic ov_t run_idle();
        ov_t e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    // Expected outputs one cycle after an instruction is accepted.
    function automatic ov_t model_decode(input int op, input int fn, input bit eqf, input bit ltf);
        ov_t e = '0;
        e.rdy = 1'b1;
        if (op == 0) begin
            if (fn == 0) e.ill = 1'b1;
            else begin
                e.aluop = 3'(fn);
                e.rw    = (fn <= 5);
            end
        end else if (op == 1) begin
            case (fn)
                0: e.sdes = 1'b1;
                1: e.ssrc = 1'b1;
                2: e.rw   = 1'b1;
                3: begin e.mr = 1'b1; e.rdy = 1'b0; end
                4: begin e.mw = 1'b1; e.rdy = 1'b0; end
                5: begin e.dn = 1'b1; e.rdy = 1'b0; end
                default: e.ill = 1'b1;
            endcase
        end else if (op == 2) begin
            case (fn)
                0: e.br = 1'b1;
                1: begin e.beq = 1'b1; e.br = eqf; end
                2: begin e.blt = 1'b1; e.br = ltf; end
                default: e.ill = 1'b1;
            endcase
        end else e.ill = 1'b1;
        return e;
    endfunction

    task automatic model_accept(input int op, input int fn, input bit eqv, input bit ltv);
        if (op == 0 && fn == 6) m_eq = eqv;
        if (op == 0 && fn == 7) m_lt = ltv;
        if (m_cnt < CMAX) m_cnt++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input int op, input int fn);
        bus.instr_valid = v;
        bus.Opcode      = OP_W'(op);
        bus.Func        = FUNC_W'(fn);
    endtask

    task automatic test_reset();
        ov_t got;
        drive(1'b1, 0, 1);
        bus.alu_eq = 1'b0; bus.alu_lt = 1'b0; bus.mem_ack = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        got = obs();
        n_chk++; if (got !== '0) $display("FAIL reset_outs: got %h want %h", got, 15'h0); else n_pass++;
        n_chk++; if (instr_count !== '0) $display("FAIL reset_count: got %0d want 0", instr_count); else n_pass++;
        m_eq = 0; m_lt = 0; m_cnt = 0;
        repeat (2) tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'(($urandom & 1)), $urandom_range(0, 7), $urandom_range(0, 7));
            bus.mem_ack = 1'($urandom & 1);
            tick();
            got = obs();
            n_chk++; if (got !== '0) $display("FAIL idle_quiet: got %h want %h", got, 15'h0); else n_pass++;
        end
        drive(1'b0, 0, 0);
        bus.mem_ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        got = obs();
        n_chk++; if (got !== run_idle()) $display("FAIL start_to_run: got %h want %h", got, run_idle()); else n_pass++;
    endtask

    task automatic test_alu_basic();
        ov_t got, e;
        e = model_decode(0, 1, m_eq, m_lt);
        drive(1'b1, 0, 1);
        tick();
        drive(1'b0, 0, 0);
        model_accept(0, 1, 1'b0, 1'b0);
        got = obs();
        n_chk++; if (got !== e) $display("FAIL lsl_decode: got %h want %h", got, e); else n_pass++;
        n_chk++; if (instr_count !== CNT_W'(m_cnt)) $display("FAIL count_first: got %0d want %0d", instr_count, m_cnt); else n_pass++;
    endtask

    task automatic test_branch_flags();
        ov_t got, e;
        for (int r = 0; r < 4; r++) begin
            bit fv = (r % 2 == 0);
            int cfn = (r < 2) ? 6 : 7;
            int bfn = (r < 2) ? 1 : 2;
            bus.alu_eq = fv; bus.alu_lt = fv;
            e = model_decode(0, cfn, m_eq, m_lt);
            drive(1'b1, 0, cfn);
            tick();
            model_accept(0, cfn, fv, fv);
            got = obs();
            n_chk++; if (got !== e) $display("FAIL cmp_decode: got %h want %h", got, e); else n_pass++;
            bus.alu_eq = ~fv; bus.alu_lt = ~fv;
            e = model_decode(2, bfn, m_eq, m_lt);
            drive(1'b1, 2, bfn);
            tick();
            drive(1'b0, 0, 0);
            model_accept(2, bfn, 1'b0, 1'b0);
            got = obs();
            n_chk++; if (got !== e) $display("FAIL branch_b2b: got %h want %h", got, e); else n_pass++;
        end
    endtask

    task automatic test_random_stream();
        ov_t got, e;
        for (int i = 0; i < 60; i++) begin
            bit v = ($urandom_range(0, 3) != 0);
            int op = $urandom_range(0, 4);
            int fn = $urandom_range(0, 7);
            bit eqv = 1'($urandom & 1), ltv = 1'($urandom & 1);
            if (op == 1 && fn >= 3 && fn <= 5) fn = 6;
            bus.alu_eq = eqv; bus.alu_lt = ltv;
            bus.mem_ack = 1'($urandom & 1);
            start = 1'($urandom & 1);
            drive(v, op, fn);
            e = v ? model_decode(op, fn, m_eq, m_lt) : run_idle();
            tick();
            if (v) model_accept(op, fn, eqv, ltv);
            got = obs();
            n_chk++; if (got !== e) $display("FAIL rand_stream op=%0d fn=%0d: got %h want %h", op, fn, got, e); else n_pass++;
        end
        drive(1'b0, 0, 0);
        start = 1'b0; bus.mem_ack = 1'b0;
        n_chk++; if (instr_count !== CNT_W'(m_cnt)) $display("FAIL count_stream: got %0d want %0d", instr_count, m_cnt); else n_pass++;
    endtask

    task automatic test_mem();
        ov_t got, e;
        int delays[4];
        delays = '{0, 3, 7, 0};
        delays[3] = $urandom_range(0, MEM_TIMEOUT - 1);
        for (int t = 0; t < 4; t++) begin
            bit ld = (t != 2);
            int fn = ld ? 3 : 4;
            e = model_decode(1, fn, m_eq, m_lt);
            bus.mem_ack = 1'b0;
            drive(1'b1, 1, fn);
            tick();
            drive(1'b0, 0, 0);
            model_accept(1, fn, 1'b0, 1'b0);
            got = obs();
            n_chk++; if (got !== e) $display("FAIL mem_enter: got %h want %h", got, e); else n_pass++;
            for (int k = 0; k < delays[t]; k++) begin
                drive(1'b1, 0, 1);
                tick();
                got = obs();
                n_chk++; if (got !== e) $display("FAIL mem_hold: got %h want %h", got, e); else n_pass++;
            end
            drive(1'b0, 0, 0);
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            e = run_idle();
            e.rw = ld;
            got = obs();
            n_chk++; if (got !== e) $display("FAIL mem_done: got %h want %h", got, e); else n_pass++;
            tick();
            got = obs();
            n_chk++; if (got !== run_idle()) $display("FAIL mem_after: got %h want %h", got, run_idle()); else n_pass++;
        end
        n_chk++; if (instr_count !== CNT_W'(m_cnt)) $display("FAIL count_mem: got %0d want %0d", instr_count, m_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        ov_t got, e, h;
        bus.alu_eq = 1'b1; bus.alu_lt = 1'b1;
        drive(1'b1, 0, 6); tick(); model_accept(0, 6, 1'b1, 1'b1);
        drive(1'b1, 0, 7); tick(); model_accept(0, 7, 1'b1, 1'b1);
        bus.mem_ack = 1'b0;
        e = model_decode(1, 4, m_eq, m_lt);
        drive(1'b1, 1, 4);
        tick();
        drive(1'b0, 0, 0);
        model_accept(1, 4, 1'b0, 1'b0);
        got = obs();
        n_chk++; if (got !== e) $display("FAIL to_enter: got %h want %h", got, e); else n_pass++;
        for (int k = 1; k < MEM_TIMEOUT; k++) begin
            tick();
            got = obs();
            n_chk++; if (got !== e) $display("FAIL to_hold: got %h want %h", got, e); else n_pass++;
        end
        h = '0; h.dn = 1'b1; h.merr = 1'b1;
        tick();
        got = obs();
        n_chk++; if (got !== h) $display("FAIL to_expire: got %h want %h", got, h); else n_pass++;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        got = obs();
        n_chk++; if (got !== h) $display("FAIL to_halt_hold: got %h want %h", got, h); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_eq = 0; m_lt = 0;
        got = obs();
        n_chk++; if (got !== run_idle()) $display("FAIL to_restart: got %h want %h", got, run_idle()); else n_pass++;
        for (int b = 1; b <= 2; b++) begin
            e = model_decode(2, b, m_eq, m_lt);
            drive(1'b1, 2, b);
            tick();
            model_accept(2, b, 1'b0, 1'b0);
            got = obs();
            n_chk++; if (got !== e) $display("FAIL flag_cleared: got %h want %h", got, e); else n_pass++;
        end
        drive(1'b0, 0, 0);
    endtask

    task automatic test_halt_illegal();
        ov_t got, e, h;
        e = model_decode(1, 5, m_eq, m_lt);
        drive(1'b1, 1, 5);
        tick();
        model_accept(1, 5, 1'b0, 1'b0);
        got = obs();
        n_chk++; if (got !== e) $display("FAIL halt_enter: got %h want %h", got, e); else n_pass++;
        h = '0; h.dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom_range(0, 2), $urandom_range(0, 7));
            tick();
            got = obs();
            n_chk++; if (got !== h) $display("FAIL halt_hold: got %h want %h", got, h); else n_pass++;
        end
        drive(1'b0, 0, 0);
        n_chk++; if (instr_count !== CNT_W'(m_cnt)) $display("FAIL halt_no_accept: got %0d want %0d", instr_count, m_cnt); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_eq = 0; m_lt = 0;
        got = obs();
        n_chk++; if (got !== run_idle()) $display("FAIL halt_restart: got %h want %h", got, run_idle()); else n_pass++;
        e = model_decode(3, 0, m_eq, m_lt);
        drive(1'b1, 3, 0);
        tick();
        drive(1'b0, 0, 0);
        model_accept(3, 0, 1'b0, 1'b0);
        got = obs();
        n_chk++; if (got !== e) $display("FAIL illegal_pulse: got %h want %h", got, e); else n_pass++;
        tick();
        got = obs();
        n_chk++; if (got !== run_idle()) $display("FAIL illegal_one_shot: got %h want %h", got, run_idle()); else n_pass++;
    endtask

    task automatic test_count_saturate();
        for (int i = 0; i < CMAX + 5; i++) begin
            drive(1'b1, 0, $urandom_range(1, 5));
            tick();
            model_accept(0, 1, 1'b0, 1'b0);
        end
        drive(1'b0, 0, 0);
        n_chk++; if (instr_count !== CNT_W'(CMAX)) $display("FAIL count_sat: got %0d want %0d", instr_count, CMAX); else n_pass++;
    endtask

    task automatic test_reset_mem_wait();
        ov_t got, e;
        bus.mem_ack = 1'b0;
        e = model_decode(1, 3, m_eq, m_lt);
        drive(1'b1, 1, 3);
        tick();
        drive(1'b0, 0, 0);
        tick();
        got = obs();
        n_chk++; if (got !== e) $display("FAIL rst_pre_mem: got %h want %h", got, e); else n_pass++;
        #2 Reset_n = 1'b0;
        #1;
        got = obs();
        n_chk++; if (got !== '0) $display("FAIL rst_mid_mem: got %h want %h", got, 15'h0); else n_pass++;
        n_chk++; if (instr_count !== '0) $display("FAIL rst_count: got %0d want 0", instr_count); else n_pass++;
        Reset_n = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        got = obs();
        n_chk++; if (got !== '0) $display("FAIL post_rst_idle: got %h want %h", got, 15'h0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_branch_flags();
        test_random_stream();
        test_mem();
        test_timeout();
        test_halt_illegal();
        test_count_saturate();
        test_reset_mem_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
